wb_regfile: RTL and testbench

//  Write-back stage consumer of the MEM/WB pipeline register: selects write data, writes the 32x32 GPR file, serves ID-stage reads.

---
 rtl/wb_regfile.sv | 136 +++++++++++++
 tb/tb_wb_regfile.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile -- write-back stage register file
//
// Consumes the MEM/WB pipeline register: selects write data (load data, ALU
// result, or jal link address), writes the NREG x 32 GPR file and serves the
// two combinational ID-stage read ports. $0 reads as zero and ignores writes.
// A registered commit record and a saturating retire counter expose every
// committed write for debug and scoreboarding.
//
// Configuration macro:
//   WB_BYPASS_EN  defined   -> same-cycle write-through bypass onto busA/busB
//                 undefined -> reads return array contents only (stale value
//                              on a same-cycle WB->ID dependence)
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   wr_dout               load data from MEM/WB
//   wr_alu_result         ALU result / link address from MEM/WB
//   wr_Rw                 destination register from MEM/WB
//   wr_RegWr              register write enable from MEM/WB
//   wr_Jump               jal: destination forced to LINK_REG, data = ALU
//   wr_MemtoReg           1: write wr_dout, 0: write wr_alu_result
//   Ra, Rb                ID-stage read addresses
//   busA, busB            ID-stage read data (combinational)
//   wb_commit             registered: a write to a nonzero register happened
//   wb_commit_Rw          registered: destination of the last committed write
//   wb_commit_data        registered: data of the last committed write
//   retire_cnt            saturating count of committed writes
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int NREG     = 32,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [31:0]             wr_dout,
    input  logic [31:0]             wr_alu_result,
    input  logic [$clog2(NREG)-1:0] wr_Rw,
    input  logic                    wr_RegWr,
    input  logic                    wr_Jump,
    input  logic                    wr_MemtoReg,
    input  logic [$clog2(NREG)-1:0] Ra,
    input  logic [$clog2(NREG)-1:0] Rb,
    output logic [31:0]             busA,
    output logic [31:0]             busB,
    output logic                    wb_commit,
    output logic [$clog2(NREG)-1:0] wb_commit_Rw,
    output logic [31:0]             wb_commit_data,
    output logic [CNT_W-1:0]        retire_cnt
);

    localparam int                AW       = $clog2(NREG);
    localparam logic [AW-1:0]     LINK_IDX = AW'(LINK_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic [31:0]      gpr_q [NREG];
    logic             commit_q;
    logic [AW-1:0]    commit_rw_q;
    logic [31:0]      commit_data_q;
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d;

    logic [AW-1:0]    dst;
    logic [31:0]      wdata;
    logic             we;

    // Destination and data selection; jal overrides both the register index
    // and the MemtoReg choice.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        dst   = wr_Rw;
        wdata = wr_alu_result;
        if (wr_Jump) begin
            dst   = LINK_IDX;
            wdata = wr_alu_result;
        end else if (wr_MemtoReg) begin
            wdata = wr_dout;
        end
    end

    // Gating with Rst_n keeps the bypass from exposing a write that the
    // array will never take while reset is held.
    assign we = wr_RegWr && (dst != '0) && Rst_n;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (we && (retire_cnt_q != CNT_MAX)) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the GPRs must come up as zero, so the array is built from
    // resettable flops rather than a RAM macro, which cannot be reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
            commit_q      <= 1'b0;
            commit_rw_q   <= '0;
            commit_data_q <= '0;
            retire_cnt_q  <= '0;
        end else begin
            if (we) begin
                gpr_q[dst]    <= wdata;
                commit_rw_q   <= dst;
                commit_data_q <= wdata;
            end
            commit_q     <= we;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Read ports resolve independently; $0 is hard-wired to zero even
    // though its array entry exists.
    assign busA = (Ra == '0) ? '0 :
                  (BYP && we && (dst == Ra)) ? wdata : gpr_q[Ra];
    assign busB = (Rb == '0) ? '0 :
                  (BYP && we && (dst == Rb)) ? wdata : gpr_q[Rb];

    assign wb_commit      = commit_q;
    assign wb_commit_Rw   = commit_rw_q;
    assign wb_commit_data = commit_data_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile -- scoreboard bench for wb_regfile
//
// The stimulus process drives one directed vector per cycle (one time unit
// after the rising edge) and pushes the hand-computed values the DUT must show
// during that cycle. The monitor samples on the falling edge and drains the
// queue. CNT_W is shrunk to 3 so retire_cnt saturation is reachable.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int CW = 3;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [31:0]   wr_dout;
    logic [31:0]   wr_alu_result;
    logic [4:0]    wr_Rw;
    logic          wr_RegWr;
    logic          wr_Jump;
    logic          wr_MemtoReg;
    logic [4:0]    Ra;
    logic [4:0]    Rb;
    logic [31:0]   busA;
    logic [31:0]   busB;
    logic          wb_commit;
    logic [4:0]    wb_commit_Rw;
    logic [31:0]   wb_commit_data;
    logic [CW-1:0] retire_cnt;

    always #5 Clk = ~Clk;

    wb_regfile #(
        .NREG    (32),
        .LINK_REG(31),
        .CNT_W   (CW)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .wr_dout       (wr_dout),
        .wr_alu_result (wr_alu_result),
        .wr_Rw         (wr_Rw),
        .wr_RegWr      (wr_RegWr),
        .wr_Jump       (wr_Jump),
        .wr_MemtoReg   (wr_MemtoReg),
        .Ra            (Ra),
        .Rb            (Rb),
        .busA          (busA),
        .busB          (busB),
        .wb_commit     (wb_commit),
        .wb_commit_Rw  (wb_commit_Rw),
        .wb_commit_data(wb_commit_data),
        .retire_cnt    (retire_cnt)
    );

    typedef enum {K_BUSA, K_BUSB, K_COMMIT, K_CRW, K_CDATA, K_CNT} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Expected read value for a same-cycle write/read pair.
    function automatic logic [31:0] byp_val(input logic [31:0] new_v,
                                            input logic [31:0] old_v);
        return BYP ? new_v : old_v;
    endfunction

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_BUSA:   return busA;
            K_BUSB:   return busB;
            K_COMMIT: return {31'd0, wb_commit};
            K_CRW:    return {27'd0, wb_commit_Rw};
            K_CDATA:  return wb_commit_data;
            default:  return {{(32-CW){1'b0}}, retire_cnt};
        endcase
    endfunction

    task automatic push_exp(input kind_e k, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic push_commit(input logic c, input logic [4:0] rw,
                               input logic [31:0] data, input logic [31:0] cnt,
                               input string tag);
        push_exp(K_COMMIT, {31'd0, c}, {tag, ".wb_commit"});
        push_exp(K_CRW,    {27'd0, rw}, {tag, ".wb_commit_Rw"});
        push_exp(K_CDATA,  data,       {tag, ".wb_commit_data"});
        push_exp(K_CNT,    cnt,        {tag, ".retire_cnt"});
    endtask

    task automatic drive(input logic regwr, input logic [4:0] rw,
                         input logic jump, input logic m2r,
                         input logic [31:0] dout, input logic [31:0] alu,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(posedge Clk);
        #1;
        wr_RegWr      = regwr;
        wr_Rw         = rw;
        wr_Jump       = jump;
        wr_MemtoReg   = m2r;
        wr_dout       = dout;
        wr_alu_result = alu;
        Ra            = ra;
        Rb            = rb;
    endtask

    // Monitor: outputs are valid every cycle, so each falling edge drains
    // everything the stimulus queued for that cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = observe(e.kind);
                n_vec++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        int wait_cnt;

        Rst_n         = 1'b0;
        wr_RegWr      = 1'b0;
        wr_Rw         = '0;
        wr_Jump       = 1'b0;
        wr_MemtoReg   = 1'b0;
        wr_dout       = '0;
        wr_alu_result = '0;
        Ra            = '0;
        Rb            = '0;

        // Reset held with a live write request: nothing may land.
        drive(1, 5, 0, 0, 32'h0, 32'h0000_AAAA, 5, 0);
        drive(1, 5, 0, 0, 32'h0, 32'h0000_AAAA, 5, 0);
        push_exp(K_BUSA, 32'h0, "rst.busA_r5");
        push_commit(0, 0, 32'h0, 0, "rst");

        // ALU write to $8; $5 must still be zero.
        drive(1, 8, 0, 0, 32'h0, 32'h0000_1234, 8, 5);
        Rst_n = 1'b1;
        push_exp(K_BUSA, byp_val(32'h0000_1234, 32'h0), "alu.busA_same_cycle");
        push_exp(K_BUSB, 32'h0, "alu.busB_r5");

        // Load write to $9 (dout wins over alu_result).
        drive(1, 9, 0, 1, 32'hDEAD_BEEF, 32'h0000_0040, 8, 9);
        push_exp(K_BUSA, 32'h0000_1234, "alu.busA_r8");
        push_exp(K_BUSB, byp_val(32'hDEAD_BEEF, 32'h0), "load.busB_same_cycle");
        push_commit(1, 8, 32'h0000_1234, 1, "alu");

        // jal with MemtoReg=1 and Rw=3: link address goes to $31.
        drive(1, 3, 1, 1, 32'h0000_5555, 32'h0040_0008, 9, 3);
        push_exp(K_BUSA, 32'hDEAD_BEEF, "load.busA_r9");
        push_exp(K_BUSB, 32'h0, "jal.busB_r3_no_bypass");
        push_commit(1, 9, 32'hDEAD_BEEF, 2, "load");

        // Write to $0 must be discarded.
        drive(1, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 31, 3);
        push_exp(K_BUSA, 32'h0040_0008, "jal.busA_r31");
        push_exp(K_BUSB, 32'h0, "jal.busB_r3");
        push_commit(1, 31, 32'h0040_0008, 3, "jal");

        // Same-cycle write/read of $10 on both ports.
        drive(1, 10, 0, 0, 32'h0, 32'h0000_0077, 10, 10);
        push_exp(K_BUSA, byp_val(32'h0000_0077, 32'h0), "byp.busA");
        push_exp(K_BUSB, byp_val(32'h0000_0077, 32'h0), "byp.busB");
        push_commit(0, 31, 32'h0040_0008, 3, "r0");

        // RegWr=0: no write, no commit; $0 reads zero.
        drive(0, 10, 0, 0, 32'h0, 32'h0000_0099, 0, 10);
        push_exp(K_BUSA, 32'h0, "r0.busA");
        push_exp(K_BUSB, 32'h0000_0077, "byp.busB_r10");
        push_commit(1, 10, 32'h0000_0077, 4, "byp");

        drive(0, 10, 0, 0, 32'h0, 32'h0000_0099, 10, 0);
        push_exp(K_BUSA, 32'h0000_0077, "idle.busA_r10");
        push_commit(0, 10, 32'h0000_0077, 4, "idle");

        // Overwrite $10 with load data.
        drive(1, 10, 0, 1, 32'h0000_CAFE, 32'h0000_0001, 10, 8);
        push_exp(K_BUSA, byp_val(32'h0000_CAFE, 32'h0000_0077), "ovr.busA_same_cycle");
        push_exp(K_BUSB, 32'h0000_1234, "ovr.busB_r8");

        drive(0, 0, 0, 0, 32'h0, 32'h0, 10, 31);
        push_exp(K_BUSA, 32'h0000_CAFE, "ovr.busA_r10");
        push_exp(K_BUSB, 32'h0040_0008, "ovr.busB_r31");
        push_commit(1, 10, 32'h0000_CAFE, 5, "ovr");

        // Asynchronous reset mid-cycle clears state without a clock edge.
        drive(0, 0, 0, 0, 32'h0, 32'h0, 10, 31);
        Rst_n = 1'b0;
        #1;
        push_exp(K_BUSA, 32'h0, "arst.busA_r10");
        push_exp(K_BUSB, 32'h0, "arst.busB_r31");
        push_commit(0, 0, 32'h0, 0, "arst");

        // After release, every edge writes $12 with value i; counter caps at 7.
        for (int i = 0; i < 10; i++) begin
            drive(1, 12, 0, 0, 32'h0, i, 12, 0);
            if (i == 0) begin
                Rst_n = 1'b1;
            end
            push_exp(K_CNT, (i > 7) ? 32'd7 : i, $sformatf("sat%0d.retire_cnt", i));
            if (i >= 1) begin
                push_exp(K_COMMIT, 32'd1, $sformatf("sat%0d.wb_commit", i));
                push_exp(K_CDATA, i - 1, $sformatf("sat%0d.wb_commit_data", i));
                push_exp(K_BUSA, byp_val(i, i - 1), $sformatf("sat%0d.busA_r12", i));
            end
        end

        drive(0, 0, 0, 0, 32'h0, 32'h0, 12, 0);
        push_exp(K_CNT, 32'd7, "sat.retire_cnt_hold");
        push_exp(K_BUSA, 32'd9, "sat.busA_final");

        // Give the monitor a bounded window to drain the scoreboard.
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge Clk);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog: the stimulus takes well under 100 cycles.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
